// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - parametrised deck dealer with burst handshake; CARD_DEALER_SHUFFLE_EN randomises the restart pointer
module card_dealer #(
    parameter int CARD_W    = 4,
    parameter int DECK_SIZE = 52,
    parameter int RANK_MAX  = 13,
    parameter int MAX_BURST = 8,
    parameter int WRAP      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           restart,
    input  logic                           deal_req,
    input  logic [3:0]                     deal_num,
    output logic                           deal_ready,
    output logic                           card_valid,
    output logic [CARD_W-1:0]              card_out,
    output logic                           card_last,
    output logic [$clog2(DECK_SIZE+1)-1:0] remaining,
    output logic                           empty,
    input  logic                           load_en,
    input  logic [$clog2(DECK_SIZE)-1:0]   load_addr,
    input  logic [CARD_W-1:0]              load_data
);
    localparam int PTR_W = $clog2(DECK_SIZE);
    localparam int REM_W = $clog2(DECK_SIZE + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DECK_SIZE - 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(DECK_SIZE);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam bit WRAP_EN = (WRAP != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;

    logic [CARD_W-1:0] deck [DECK_SIZE];
    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  restart_ptr;
    logic [REM_W-1:0]  rem_next;
    logic [3:0]        burst_cnt;
    logic              num_ok;
    logic              exhaust;
    logic              last_card;

    assign num_ok    = (deal_num != 4'd0) && (deal_num <= 4'(MAX_BURST));
    // Without wrap, the card that drains the deck always closes the burst.
    assign exhaust   = !WRAP_EN && (remaining == REM_ONE);
    assign last_card = (burst_cnt == 4'd1) || exhaust;

`ifdef CARD_DEALER_SHUFFLE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_mod;

    assign lfsr_mod    = lfsr % 16'(DECK_SIZE);
    assign restart_ptr = lfsr_mod[PTR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Random start point: the pointer always wraps and the round is bounded by remaining.
    assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    assign rem_next = (WRAP_EN && remaining == REM_ONE) ? REM_FULL :
                      (remaining == '0) ? '0 : remaining - REM_ONE;
`else
    assign restart_ptr = '0;
    assign ptr_next = (ptr == PTR_LAST) ? (WRAP_EN ? '0 : ptr) : ptr + PTR_W'(1);
    assign rem_next = (WRAP_EN && ptr == PTR_LAST) ? REM_FULL :
                      (remaining == '0) ? '0 : remaining - REM_ONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DECK_SIZE; i++) begin
                deck[i] <= CARD_W'((i % RANK_MAX) + 1);
            end
        end else if (load_en && (32'(load_addr) < DECK_SIZE)) begin
            deck[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= REM_FULL;
            burst_cnt <= 4'd0;
        end else if (restart) begin
            state     <= S_IDLE;
            ptr       <= restart_ptr;
            remaining <= REM_FULL;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (deal_req && num_ok) begin
                        state     <= S_BURST;
                        burst_cnt <= deal_num;
                    end
                end
                S_BURST: begin
                    ptr       <= ptr_next;
                    remaining <= rem_next;
                    burst_cnt <= burst_cnt - 4'd1;
                    if (last_card) begin
                        state <= exhaust ? S_EMPTY : S_IDLE;
                    end
                end
                S_EMPTY: begin
                    state <= S_EMPTY;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign deal_ready = (state == S_IDLE);
    assign card_valid = (state == S_BURST);
    assign card_out   = card_valid ? deck[ptr] : '0;
    assign card_last  = card_valid && last_card;
    assign empty      = !WRAP_EN && (remaining == '0);
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Parametrised deck/shoe dealer: holds DECK_SIZE card ranks in an internal register array and deals them in order, one per cycle.
- Successor to the fixed 52-card single-step lookup table. Adds:
  - configurable width and depth
  - runtime deck loading
  - multi-card burst deals with a ready/valid style handshake
  - remaining-card tracking
  - wrap or stop-at-empty mode
- Sits between the game controller FSM (issues deal requests) and the hand scoring logic (consumes cards).

Parameters:
- CARD_W, 4: width of one card rank.
- DECK_SIZE, 52: number of entries in the deck array (2..256).
- RANK_MAX, 13: reset fill pattern modulus; entry i resets to (i mod RANK_MAX)+1.
- MAX_BURST, 8: largest number of cards in one deal request (1..15).
- WRAP, 0: 1 = pointer wraps after last card, never empty; 0 = stop and flag empty.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- restart  in  1  one-cycle pulse: reset deal pointer and count, deck contents kept
- deal_req  in  1  request a burst; accepted only when deal_ready=1
- deal_num  in  4  cards requested in burst (1..MAX_BURST), sampled on acceptance
- deal_ready  out  1  high in IDLE when deal_num>0 would be accepted
- card_valid  out  1  card_out holds a dealt card this cycle
- card_out  out  CARD_W  dealt rank; 0 whenever card_valid=0
- card_last  out  1  with card_valid: final card of current burst
- remaining  out  clog2(DECK_SIZE+1)  cards not yet dealt since reset/restart
- empty  out  1  remaining==0 and WRAP==0
- load_en  in  1  write one deck entry
- load_addr  in  clog2(DECK_SIZE)  entry index; writes with load_addr>=DECK_SIZE are ignored
- load_data  in  CARD_W  rank to write

Behaviour:
- Reset (rst high, async):
  - outputs: card_out=0, card_valid=0, card_last=0, remaining=DECK_SIZE, empty=0, deal_ready=1.
  - internal state: pointer=0, FSM=IDLE, deck[i]=(i mod RANK_MAX)+1.
- FSM states:
  - IDLE: deal_ready=1.
  - BURST: deal_ready=0; outputting cards.
  - EMPTY: deal_ready=0; only reachable when WRAP=0.
- IDLE -> BURST: on deal_req=1 with deal_num in 1..MAX_BURST.
  - deal_num=0 or deal_num>MAX_BURST: request ignored, stay IDLE.
- Latency: request accepted at edge T. First card_valid is high in the cycle after T, then one card per cycle back-to-back, with no gaps.
- Per card dealt:
  - card_out = deck[pointer]
  - pointer advances: if pointer==DECK_SIZE-1 it goes to 0 (WRAP=1) or holds (WRAP=0); otherwise pointer+1
  - remaining decrements, saturating at 0
  - in WRAP=1 mode remaining reloads to DECK_SIZE when the pointer wraps
- Burst end:
  - card_last=1 on the Nth card; next cycle the FSM returns to IDLE, card_valid=0, card_out=0.
- Deck exhausted mid-burst (WRAP=0): burst truncates.
  - The card that takes remaining to 0 carries card_last=1.
  - FSM goes to EMPTY and empty rises in the same cycle remaining reads 0.
- EMPTY: deal_req ignored; restart returns to IDLE.
- restart:
  - effect: pointer=0, remaining=DECK_SIZE, empty=0, FSM=IDLE, card_valid=0 next cycle.
  - priority: beats any in-flight burst; a burst in progress is aborted with no card_last.
  - with deal_req in the same cycle: the request is ignored.
- load_en:
  - allowed in any state; write takes effect at the edge.
  - a card dealt from the same address in the same cycle returns the old value (read-before-write).
  - load does not change pointer or remaining.
- Widths: pointer is clog2(DECK_SIZE) bits. Burst counter is 4 bits. No arithmetic overflow is permitted (explicit compare against DECK_SIZE-1).

Optional Feature:
- Macro CARD_DEALER_SHUFFLE_EN.
- Defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) free-runs every cycle.
  - on restart, pointer loads (LFSR mod DECK_SIZE) instead of 0.
  - dealing wraps modulo DECK_SIZE from that start; exhaustion is tracked only by remaining (DECK_SIZE cards per round).
  - reset still starts at pointer 0.
- Not defined: no LFSR; restart always loads pointer 0; behaviour exactly as above.

Test Plan:
- Reset, deal_req with deal_num=3 -> card_valid for 3 consecutive cycles starting 1 cycle after acceptance; card_out=1,2,3; card_last on 3rd; remaining=49; deal_ready back to 1.
- WRAP=0, DECK_SIZE=52: deal 6 bursts of 8 then deal_num=8 with 4 left -> 4 cards (ranks 10,11,12,13), card_last on 4th, empty=1, next deal_req ignored.
- WRAP=1: deal 53 cards -> 53rd card_out=1 (entry 0 again); remaining reloads to 52 at wrap; empty never asserts.
- load_en addr=0 data=9 in the same cycle the 1st card of a burst is dealt from entry 0 -> that card outputs 1; after restart a deal of 1 card outputs 9.
- restart asserted during card 2 of a 5-card burst -> card_valid=0 next cycle, no card_last, remaining=52, next deal starts at entry 0.
- deal_num=0 and deal_num=9 (MAX_BURST=8) -> no card_valid, deal_ready stays 1; with CARD_DEALER_SHUFFLE_EN, restart at a known LFSR value -> first card is from entry LFSR mod 52.
